// File: rtl/mac_pkg.sv
// Shared types and default sizing for the MAC accumulator.
package mac_pkg;
  typedef enum logic {IDLE, ACCUM} state_t;

  localparam int DEF_BITWIDTH_PRODUCT = 64;
  localparam int DEF_BITWIDTH_ACC     = 68;
  localparam int DEF_VEC_LEN          = 16;

  // Counter width; a single-term vector still needs a 1-bit counter.
  function automatic int cnt_width(input int vec_len);
    return (vec_len > 1) ? $clog2(vec_len) : 1;
  endfunction
endpackage

// File: rtl/sat_adder.sv
// Unsigned adder that clamps to all-ones on carry out.
module sat_adder #(
  parameter int WIDTH = 68
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] sum,
  output logic             sat
);
  logic [WIDTH:0] full;

  assign full = {1'b0, a} + {1'b0, b};
  assign sat  = full[WIDTH];
  assign sum  = full[WIDTH] ? {WIDTH{1'b1}} : full[WIDTH-1:0];
endmodule

// File: rtl/mac_accumulator.sv
// Sums VEC_LEN unsigned products with saturation; publishes each vector sum
// with a one-cycle acc_valid pulse and a per-vector overflow flag.
module mac_accumulator
  import mac_pkg::*;
#(
  parameter int BITWIDTH_PRODUCT = DEF_BITWIDTH_PRODUCT,
  parameter int BITWIDTH_ACC     = DEF_BITWIDTH_ACC,
  parameter int VEC_LEN          = DEF_VEC_LEN
) (
  input  logic                        clk,
  input  logic                        rstn,
  input  logic                        clr,
  input  logic [BITWIDTH_PRODUCT-1:0] p,
  input  logic                        p_valid,
  output logic [BITWIDTH_ACC-1:0]     acc,
  output logic                        acc_valid,
  output logic                        ovf,
  output logic                        busy
);
  localparam int CW = cnt_width(VEC_LEN);

  state_t                  state, state_next;
  logic [CW-1:0]           cnt;
  logic [BITWIDTH_ACC-1:0] psum, p_ext, add_a, add_sum;
  logic                    sticky, add_sat, last, sticky_next;

  assign p_ext = BITWIDTH_ACC'(p);
  assign last  = (cnt == CW'(VEC_LEN - 1));
  // The first term of a vector loads rather than adds.
  assign add_a = (state == IDLE) ? '0 : psum;
  assign sticky_next = ((state == IDLE) ? 1'b0 : sticky) | add_sat;
  assign busy  = (state == ACCUM);

  sat_adder #(.WIDTH(BITWIDTH_ACC)) u_add (
    .a   (add_a),
    .b   (p_ext),
    .sum (add_sum),
    .sat (add_sat)
  );

  always_comb begin
    state_next = state;
    if (clr)          state_next = IDLE;
    else if (p_valid) state_next = last ? IDLE : ACCUM;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= IDLE;
    else       state <= state_next;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt       <= '0;
      psum      <= '0;
      sticky    <= 1'b0;
      acc       <= '0;
      ovf       <= 1'b0;
      acc_valid <= 1'b0;
    end else begin
      acc_valid <= 1'b0;
      if (clr) begin
        cnt    <= '0;
        psum   <= '0;
        sticky <= 1'b0;
      end else if (p_valid) begin
        if (last) begin
          acc       <= add_sum;
          ovf       <= sticky_next;
          acc_valid <= 1'b1;
          cnt       <= '0;
          psum      <= '0;
          sticky    <= 1'b0;
        end else begin
          psum   <= add_sum;
          sticky <= sticky_next;
          cnt    <= cnt + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_mac_accumulator.sv
// Directed bench: default-size vectors from a table, plus clr, reset,
// saturation (ACC=66, VEC_LEN=8) and single-term (VEC_LEN=1) sequences.
module tb_mac_accumulator;
  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        clr, p_valid, acc_valid, ovf, busy;
  logic [63:0] p;
  logic [67:0] acc;
  mac_accumulator dut (.clk(clk), .rstn(rstn), .clr(clr), .p(p), .p_valid(p_valid),
                       .acc(acc), .acc_valid(acc_valid), .ovf(ovf), .busy(busy));

  logic        clr2, p_valid2, acc_valid2, ovf2, busy2;
  logic [63:0] p2;
  logic [65:0] acc2;
  mac_accumulator #(.BITWIDTH_PRODUCT(64), .BITWIDTH_ACC(66), .VEC_LEN(8)) dut2 (
    .clk(clk), .rstn(rstn), .clr(clr2), .p(p2), .p_valid(p_valid2),
    .acc(acc2), .acc_valid(acc_valid2), .ovf(ovf2), .busy(busy2));

  logic       clr3, p_valid3, acc_valid3, ovf3, busy3;
  logic [7:0] p3, acc3;
  mac_accumulator #(.BITWIDTH_PRODUCT(8), .BITWIDTH_ACC(8), .VEC_LEN(1)) dut3 (
    .clk(clk), .rstn(rstn), .clr(clr3), .p(p3), .p_valid(p_valid3),
    .acc(acc3), .acc_valid(acc_valid3), .ovf(ovf3), .busy(busy3));

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [63:0] p0;
    logic [63:0] step;
    int          gap;
    logic [67:0] exp_acc;
    logic        exp_ovf;
  } vec_t;
  vec_t tbl[5];

  // Feeds 16 terms into the default instance, recording every pulse seen.
  task automatic feed(input logic [63:0] p0, input logic [63:0] step, input int gap,
                      output int pulses, output logic [67:0] acc_at, output logic ovf_at,
                      output int pulse_cyc, output int last_cyc);
    pulses = 0; acc_at = '0; ovf_at = 1'b0; pulse_cyc = -1; last_cyc = -1;
    for (int k = 0; k < 16; k++) begin
      p_valid = 1'b1;
      p = p0 + step * 64'(k);
      tick();
      if (k == 15) last_cyc = cyc;
      if (acc_valid) begin pulses++; acc_at = acc; ovf_at = ovf; pulse_cyc = cyc; end
      if (k != 15) begin
        for (int g = 0; g < gap; g++) begin
          p_valid = 1'b0;
          p = 64'hDEAD;
          tick();
          if (acc_valid) begin pulses++; pulse_cyc = cyc; end
        end
      end
    end
    p_valid = 1'b0;
  endtask

  initial begin
    int pulses, pc, lc, prev_pc;
    logic [67:0] a_at, acc_before;
    logic o_at;

    tbl[0] = '{64'd0, 64'd3, 0, 68'd360, 1'b0};
    tbl[1] = '{64'd1, 64'd0, 0, 68'd16,  1'b0};
    tbl[2] = '{64'd2, 64'd0, 0, 68'd32,  1'b0};
    tbl[3] = '{64'd5, 64'd0, 2, 68'd80,  1'b0};
    tbl[4] = '{64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 0, 68'hF_FFFF_FFFF_FFFF_FFF0, 1'b0};

    clr = 0; p_valid = 0; p = '0;
    clr2 = 0; p_valid2 = 0; p2 = '0;
    clr3 = 0; p_valid3 = 0; p3 = '0;

    // Reset state, with a valid term offered while held in reset.
    p_valid = 1'b1; p = 64'd9;
    tick(); tick();
    chk("rst_acc", acc, 0);
    chk("rst_valid", acc_valid, 0);
    chk("rst_ovf", ovf, 0);
    chk("rst_busy", busy, 0);
    p_valid = 1'b0;
    rstn = 1'b1;
    tick();

    prev_pc = 0;
    for (int i = 0; i < 5; i++) begin
      feed(tbl[i].p0, tbl[i].step, tbl[i].gap, pulses, a_at, o_at, pc, lc);
      chk($sformatf("tbl%0d_pulses", i), pulses, 1);
      chk($sformatf("tbl%0d_acc", i), a_at, tbl[i].exp_acc);
      chk($sformatf("tbl%0d_ovf", i), o_at, tbl[i].exp_ovf);
      chk($sformatf("tbl%0d_timing", i), pc, lc);
      if (i == 2) chk("b2b_spacing", pc - prev_pc, 16);
      prev_pc = pc;
    end
    tick();
    chk("pulse_one_cycle", acc_valid, 0);
    chk("acc_held", acc, tbl[4].exp_acc);

    // clr with p_valid mid-vector: term dropped, no pulse, acc/ovf untouched.
    acc_before = acc;
    for (int k = 0; k < 5; k++) begin p_valid = 1; p = 64'd10; tick(); end
    chk("clr_busy_before", busy, 1);
    clr = 1'b1; p_valid = 1'b1; p = 64'd10;
    tick();
    clr = 1'b0; p_valid = 1'b0;
    chk("clr_no_pulse", acc_valid, 0);
    chk("clr_busy_after", busy, 0);
    chk("clr_acc_kept", acc, acc_before);
    chk("clr_ovf_kept", ovf, 0);
    feed(64'd1, 64'd0, 0, pulses, a_at, o_at, pc, lc);
    chk("clr_next_pulses", pulses, 1);
    chk("clr_next_acc", a_at, 16);

    // Reset mid-vector discards the partial sum.
    for (int k = 0; k < 7; k++) begin p_valid = 1; p = 64'd2; tick(); end
    p_valid = 1'b0;
    rstn = 1'b0;
    #1;
    chk("mid_rst_acc", acc, 0);
    chk("mid_rst_valid", acc_valid, 0);
    chk("mid_rst_busy", busy, 0);
    tick(); tick();
    rstn = 1'b1;
    tick();
    feed(64'd2, 64'd0, 0, pulses, a_at, o_at, pc, lc);
    chk("post_rst_pulses", pulses, 1);
    chk("post_rst_acc", a_at, 32);

    // Saturation on the narrow instance, then a clean vector.
    for (int k = 0; k < 8; k++) begin
      p_valid2 = 1'b1; p2 = 64'hFFFF_FFFF_FFFF_FFFF; tick();
      if (k < 7) chk($sformatf("sat_early%0d", k), acc_valid2, 0);
    end
    chk("sat_valid", acc_valid2, 1);
    chk("sat_acc", acc2, {66{1'b1}});
    chk("sat_ovf", ovf2, 1);
    for (int k = 0; k < 8; k++) begin p_valid2 = 1'b1; p2 = 64'd1; tick(); end
    p_valid2 = 1'b0;
    chk("clean_valid", acc_valid2, 1);
    chk("clean_acc", acc2, 8);
    chk("clean_ovf", ovf2, 0);

    // Single-term vectors: each accepted term is a result, never busy.
    p_valid3 = 1'b1; p3 = 8'd7; tick();
    chk("v1_valid_a", acc_valid3, 1);
    chk("v1_acc_a", acc3, 7);
    chk("v1_busy", busy3, 0);
    p3 = 8'd200; tick();
    chk("v1_valid_b", acc_valid3, 1);
    chk("v1_acc_b", acc3, 200);
    p_valid3 = 1'b0; p3 = 8'd55; tick();
    chk("v1_idle_valid", acc_valid3, 0);
    chk("v1_idle_acc", acc3, 200);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mac_accumulator.md
MAC_ACCUMULATOR -- requirements
Module: mac_accumulator

Interface
REQ-001 SHALL have parameter BITWIDTH_PRODUCT, default 64: width of the incoming unsigned product.
REQ-002 SHALL have parameter BITWIDTH_ACC, default 68: accumulator/result width; SHALL be >= BITWIDTH_PRODUCT.
REQ-003 SHALL have parameter VEC_LEN, default 16: products summed per result; SHALL be >= 1.
REQ-004 SHALL have one clock; reset is asynchronous and active-low, ports named clk and rstn.
REQ-005 clk  input  1  sole clock, all state on rising edge.
REQ-006 rstn  input  1  asynchronous active-low reset.
REQ-007 clr  input  1  synchronous abort: discard the partial sum and restart the vector.
REQ-008 p  input  BITWIDTH_PRODUCT  unsigned product from the upstream multiplier.
REQ-009 p_valid  input  1  p is a valid term this cycle; no backpressure.
REQ-010 acc  output  BITWIDTH_ACC  last completed vector sum, held until the next completion.
REQ-011 acc_valid  output  1  one-cycle pulse when acc updates.
REQ-012 ovf  output  1  the vector in acc saturated; updates with acc.
REQ-013 busy  output  1  high while a partial vector is held (state ACCUM).

Function
REQ-014 SHALL implement states IDLE (no partial sum) and ACCUM (1..VEC_LEN-1 terms held).
REQ-015 Transitions: IDLE->ACCUM on accepted p_valid when VEC_LEN>1; ACCUM->IDLE on the VEC_LEN-th term or on clr; all others hold.
REQ-016 Term counter SHALL count 0..VEC_LEN-1 and wrap to 0 on the VEC_LEN-th accepted term.
REQ-017 The first term of a vector SHALL load the partial sum (zero-extended p); later terms SHALL add zero-extended p to it.
REQ-018 Additions SHALL saturate at 2^BITWIDTH_ACC-1; any saturation SHALL set an internal sticky flag for the current vector.
REQ-019 On the VEC_LEN-th term, acc, ovf and acc_valid SHALL register on the same edge as the final addition: acc_valid is high in the cycle after the last p_valid cycle.
REQ-020 acc_valid SHALL be high for exactly one cycle per completed vector; back-to-back vectors with no idle cycle SHALL each produce one pulse.
REQ-021 The sticky flag and the partial sum SHALL clear when a vector completes, so the next vector starts clean.
REQ-022 clr SHALL return the block to IDLE, zero the counter, clear the sticky flag, and leave acc/ovf unchanged with no acc_valid pulse.
REQ-023 clr and p_valid in the same cycle: clr wins and the term is dropped.
REQ-024 With VEC_LEN=1, every accepted term SHALL produce a result; the block stays in IDLE.
REQ-025 p SHALL be ignored whenever p_valid is low.

Reset
REQ-026 While rstn is low: state=IDLE, counter=0, partial sum=0, sticky flag=0, acc=0, acc_valid=0, ovf=0, busy=0.
REQ-027 Reset asserted mid-vector SHALL discard the partial sum with no acc_valid pulse.
REQ-028 The first p_valid after reset release SHALL be term 0 of a new vector.

Structure
REQ-029 Package mac_pkg SHALL hold the state enum (IDLE, ACCUM) and the default-parameter constants.
REQ-030 Saturating addition SHALL be a sub-module sat_adder (parameterised width, combinational sum plus saturate flag).
REQ-031 Target size: 120-400 lines of RTL.

Verification (defaults unless stated)
REQ-032 Feed p=3*k for k=0..15 on 16 consecutive cycles -> one acc_valid pulse the cycle after the last term, acc=360, ovf=0.
REQ-033 Feed two back-to-back vectors (all p=1, then all p=2), 32 cycles -> two pulses, 16 cycles apart; acc=16 then 32.
REQ-034 BITWIDTH_ACC=66, VEC_LEN=8, all p=2^64-1 -> acc=2^66-1, ovf=1; next vector of p=1 -> acc=8, ovf=0.
REQ-035 Feed 5 terms p=10, assert clr with p_valid high on the 6th, then 16 terms p=1 -> no pulse after the 6th cycle; next pulse acc=16; busy low for the cycle after clr.
REQ-036 Drop rstn after 7 terms, release it, then feed 16 terms p=2 -> acc=0 and acc_valid=0 during reset; next result acc=32.
REQ-037 Gapped p_valid (one cycle high, two low, p=5 x16; p held at 0xDEAD while invalid) -> acc=80, exactly one pulse.
